data_mem_resp: RTL

Data-memory responder on the far side of the MEM-stage memory interface. It accepts chip-enable, write-enable, address and write-data from the MEM stage. It services word reads and writes after a fixed, parameterised number of wait states, and returns read data with a one-cycle acknowledge. Together with the single-cycle/pipelined core it forms the data-side memory model used for simulation.

---
 rtl/data_mem_resp_if.sv | 34 +++
 rtl/data_mem_resp.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/data_mem_resp_if.sv
// MEM-stage data-memory bus between the core and the data-memory responder.
// master: core side (drives request); slave: responder (drives response).
interface data_mem_resp_if;
    logic        MemCE_i;
    logic        MemWE_i;
    logic [31:0] MemAddr_i;
    logic [31:0] MemData_i;
    logic [31:0] MemData_o;
    logic        MemAck_o;
    logic        Busy_o;
    logic        MisAlign_o;

    modport master (
        output MemCE_i,
        output MemWE_i,
        output MemAddr_i,
        output MemData_i,
        input  MemData_o,
        input  MemAck_o,
        input  Busy_o,
        input  MisAlign_o
    );

    modport slave (
        input  MemCE_i,
        input  MemWE_i,
        input  MemAddr_i,
        input  MemData_i,
        output MemData_o,
        output MemAck_o,
        output Busy_o,
        output MisAlign_o
    );
endinterface

// File: rtl/data_mem_resp.sv
// Data-memory responder: word reads/writes after WAIT_CYCLES wait states,
// one-cycle MemAck_o, registered read data held until the next read.
// Ports: clk, rst (async, active-high), bus (data_mem_resp_if.slave).
// Optional: DMEM_MISALIGN_CHK_EN flags and suppresses misaligned accesses.
module data_mem_resp #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_resp_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic capture;
    logic enter_resp;

    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  we_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;

    logic [31:0] mem [DEPTH];

    // With zero wait states the response edge is the capture edge, so the
    // access must use the live request rather than the captured copy.
    logic                  in_idle;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  acc_we;
    logic [31:0]           acc_wdata;
    logic                  acc_ok;

    assign in_idle   = (state_q == IDLE);
    assign acc_idx   = in_idle ? bus.MemAddr_i[ADDR_WIDTH+1:2] : idx_q;
    assign acc_we    = in_idle ? bus.MemWE_i : we_q;
    assign acc_wdata = in_idle ? bus.MemData_i : wdata_q;

`ifdef DMEM_MISALIGN_CHK_EN
    logic err_q;
    logic acc_err;

    assign acc_err = in_idle ? (bus.MemAddr_i[1:0] != 2'b00) : err_q;
    assign acc_ok  = ~acc_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (capture) begin
            err_q <= (bus.MemAddr_i[1:0] != 2'b00);
        end
    end

    assign bus.MisAlign_o = (state_q == RESP) & err_q;
`else
    assign acc_ok         = 1'b1;
    assign bus.MisAlign_o = 1'b0;
`endif

    // Upper address bits alias and byte-offset bits carry no data.
    logic unused_addr;
    assign unused_addr = ^{bus.MemAddr_i[31:ADDR_WIDTH+2],
                           bus.MemAddr_i[1:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        capture     = 1'b0;
        enter_resp  = 1'b0;
        bus.MemAck_o = 1'b0;
        bus.Busy_o   = 1'b1;
        unique case (state_q)
            IDLE: begin
                bus.Busy_o = 1'b0;
                if (bus.MemCE_i) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                bus.MemAck_o = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
        end else if (capture) begin
            idx_q   <= bus.MemAddr_i[ADDR_WIDTH+1:2];
            we_q    <= bus.MemWE_i;
            wdata_q <= bus.MemData_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if (enter_resp && !acc_we) begin
            rdata_q <= acc_ok ? mem[acc_idx] : 32'd0;
        end
    end

    // Array is not reset; a write still in flight when rst rises is dropped.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && acc_we && acc_ok) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.MemData_o = rdata_q;

endmodule
